// File: rtl/mem_arbiter_if.sv
// Requester and shared-memory-port signal bundle for mem_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface mem_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic          pipe_flush;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_write;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [SW-1:0] dm_wstrb;
   logic          dm_ack;
   logic [DW-1:0] dm_rdata;
   logic          bus_valid;
   logic          bus_write;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [SW-1:0] bus_wstrb;
   logic          bus_ready;
   logic [DW-1:0] bus_rdata;

   modport slave (
      input  pipe_flush, if_req, if_addr, dm_req, dm_write, dm_addr, dm_wdata, dm_wstrb,
             bus_ready, bus_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata,
             bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb
   );

   modport master (
      output pipe_flush, if_req, if_addr, dm_req, dm_write, dm_addr, dm_wdata, dm_wstrb,
             bus_ready, bus_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata,
             bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb
   );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single memory port; data wins ties, flushed fetches complete silently.
// Optional macro FETCH_STARVE_GUARD_EN lets a waiting fetch win after STARVE_LIMIT data grants.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave arb
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned CW = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_limit_check
      $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
   end

   logic [1:0]    state, state_nx;
   logic          fetch_gnt, fetch_gnt_nx;
   logic          squash, squash_nx;
   logic [DW-1:0] cap, cap_nx;
   logic          bus_valid_nx, bus_write_nx;
   logic [AW-1:0] bus_addr_nx;
   logic [DW-1:0] bus_wdata_nx;
   logic [SW-1:0] bus_wstrb_nx;
   logic          if_ack_nx, dm_ack_nx;
   logic [DW-1:0] if_rdata_nx, dm_rdata_nx;
   logic          starve_win, pick_fetch;
`ifdef FETCH_STARVE_GUARD_EN
   logic [CW-1:0] starve_cnt, starve_cnt_nx;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_nx     = state;
      fetch_gnt_nx = fetch_gnt;
      squash_nx    = squash;
      cap_nx       = cap;
      bus_valid_nx = arb.bus_valid;
      bus_write_nx = arb.bus_write;
      bus_addr_nx  = arb.bus_addr;
      bus_wdata_nx = arb.bus_wdata;
      bus_wstrb_nx = arb.bus_wstrb;
      if_ack_nx    = 1'b0;
      dm_ack_nx    = 1'b0;
      if_rdata_nx  = arb.if_rdata;
      dm_rdata_nx  = arb.dm_rdata;
`ifdef FETCH_STARVE_GUARD_EN
      starve_cnt_nx = starve_cnt;
      starve_win    = arb.if_req && (starve_cnt == CW'(STARVE_LIMIT));
`else
      starve_win    = 1'b0;
`endif
      pick_fetch = arb.if_req && (!arb.dm_req || starve_win);

      case (state)
         IDLE: begin
            if (arb.if_req || arb.dm_req) begin
               state_nx     = BUS;
               bus_valid_nx = 1'b1;
               fetch_gnt_nx = pick_fetch;
               squash_nx    = 1'b0;
               if (pick_fetch) begin
                  bus_write_nx = 1'b0;
                  bus_addr_nx  = arb.if_addr;
                  bus_wdata_nx = '0;
                  bus_wstrb_nx = '0;
`ifdef FETCH_STARVE_GUARD_EN
                  starve_cnt_nx = '0;
`endif
               end else begin
                  bus_write_nx = arb.dm_write;
                  bus_addr_nx  = arb.dm_addr;
                  bus_wdata_nx = arb.dm_wdata;
                  bus_wstrb_nx = arb.dm_wstrb;
`ifdef FETCH_STARVE_GUARD_EN
                  if (arb.if_req) starve_cnt_nx = starve_cnt + CW'(1);
`endif
               end
            end
         end
         BUS: begin
            if (fetch_gnt && arb.pipe_flush) squash_nx = 1'b1;
            if (arb.bus_ready) begin
               cap_nx       = arb.bus_rdata;
               bus_valid_nx = 1'b0;
               state_nx     = ACK;
            end
         end
         ACK: begin
            // A flush arriving in this very cycle still squashes the fetch
            state_nx = IDLE;
            if (fetch_gnt) begin
               if (!squash && !arb.pipe_flush) begin
                  if_ack_nx   = 1'b1;
                  if_rdata_nx = cap;
               end
            end else begin
               dm_ack_nx   = 1'b1;
               dm_rdata_nx = cap;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         fetch_gnt     <= 1'b0;
         squash        <= 1'b0;
         cap           <= '0;
         arb.bus_valid <= 1'b0;
         arb.bus_write <= 1'b0;
         arb.bus_addr  <= '0;
         arb.bus_wdata <= '0;
         arb.bus_wstrb <= '0;
         arb.if_ack    <= 1'b0;
         arb.dm_ack    <= 1'b0;
         arb.if_rdata  <= '0;
         arb.dm_rdata  <= '0;
`ifdef FETCH_STARVE_GUARD_EN
         starve_cnt    <= '0;
`endif
      end else begin
         state         <= state_nx;
         fetch_gnt     <= fetch_gnt_nx;
         squash        <= squash_nx;
         cap           <= cap_nx;
         arb.bus_valid <= bus_valid_nx;
         arb.bus_write <= bus_write_nx;
         arb.bus_addr  <= bus_addr_nx;
         arb.bus_wdata <= bus_wdata_nx;
         arb.bus_wstrb <= bus_wstrb_nx;
         arb.if_ack    <= if_ack_nx;
         arb.dm_ack    <= dm_ack_nx;
         arb.if_rdata  <= if_rdata_nx;
         arb.dm_rdata  <= dm_rdata_nx;
`ifdef FETCH_STARVE_GUARD_EN
         starve_cnt    <= starve_cnt_nx;
`endif
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory slave, transaction-level reference model.
module tb_mem_arbiter;
   localparam int unsigned LIMIT = 4;
`ifdef FETCH_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   mem_arbiter_if arb();
   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .arb(arb));
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   txn_t log_q[$];
   int   slave_wait = 0;
   bit   slave_rand = 1'b0;
   int   stable_err = 0, if_ack_cnt = 0, dm_ack_cnt = 0, both_cnt = 0;
   int   wait_cnt = 0, target = 0;
   bit   in_txn = 1'b0;
   txn_t cur, cur_now;
   int   model_starve = 0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // Memory slave: optional wait states, records each completed transaction, watches stability
   always @(negedge clk) begin
      if (!rst_n || !arb.bus_valid) begin
         arb.bus_ready = 1'b0;
         arb.bus_rdata = $urandom;
         in_txn        = 1'b0;
      end else begin
         cur_now = {arb.bus_write, arb.bus_addr, arb.bus_wdata, arb.bus_wstrb};
         if (!in_txn) begin
            in_txn   = 1'b1;
            cur      = cur_now;
            wait_cnt = 0;
            target   = slave_rand ? int'($urandom_range(0, 3)) : slave_wait;
         end else if (cur_now !== cur) begin
            stable_err++;
         end
         if (wait_cnt == target) begin
            arb.bus_rdata = mem_rd(cur.addr);
            arb.bus_ready = 1'b1;
            if (cur.write) mem[cur.addr] = merge(mem_rd(cur.addr), cur.wdata, cur.wstrb);
            log_q.push_back(cur);
            wait_cnt++;
         end else begin
            arb.bus_ready = 1'b0;
            arb.bus_rdata = $urandom;
            if (wait_cnt < target) wait_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (arb.if_ack) if_ack_cnt++;
         if (arb.dm_ack) dm_ack_cnt++;
         if (arb.if_ack && arb.dm_ack) both_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      arb.pipe_flush = 1'b0;
      arb.if_req     = 1'b0;
      arb.if_addr    = '0;
      arb.dm_req     = 1'b0;
      arb.dm_write   = 1'b0;
      arb.dm_addr    = '0;
      arb.dm_wdata   = '0;
      arb.dm_wstrb   = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic run_one(input bit fetch, input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                          input logic [3:0] st, output int cycles, output logic [31:0] rdata, output bit got);
      got = 1'b0; cycles = 0; rdata = '0;
      if (fetch) begin
         arb.if_req = 1'b1; arb.if_addr = addr;
      end else begin
         arb.dm_req = 1'b1; arb.dm_write = wr; arb.dm_addr = addr; arb.dm_wdata = wd; arb.dm_wstrb = st;
      end
      for (int i = 1; i <= 60 && !got; i++) begin
         cyc();
         if (fetch ? arb.if_ack : arb.dm_ack) begin
            got = 1'b1; cycles = i; rdata = fetch ? arb.if_rdata : arb.dm_rdata;
         end
      end
      arb.if_req = 1'b0;
      arb.dm_req = 1'b0;
   endtask

   task automatic test_reset();
      bit got = 1'b0;
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) cyc();
      n_checks++; if (arb.bus_valid !== 1'b0 || arb.bus_write !== 1'b0) $display("FAIL reset_valid_write: got %b%b required 00", arb.bus_valid, arb.bus_write); else n_pass++;
      n_checks++; if ({arb.bus_addr, arb.bus_wdata, arb.bus_wstrb} !== 68'h0) $display("FAIL reset_bus_fields: got %h %h %h required zeros", arb.bus_addr, arb.bus_wdata, arb.bus_wstrb); else n_pass++;
      n_checks++; if (arb.if_ack !== 1'b0 || arb.dm_ack !== 1'b0) $display("FAIL reset_acks: got %b%b required 00", arb.if_ack, arb.dm_ack); else n_pass++;
      n_checks++; if (arb.if_rdata !== 32'h0 || arb.dm_rdata !== 32'h0) $display("FAIL reset_rdata: got %h %h required zeros", arb.if_rdata, arb.dm_rdata); else n_pass++;
      // first grant must happen at the first edge after release
      slave_rand = 1'b0; slave_wait = 0;
      rst_n = 1'b1;
      arb.dm_req = 1'b1; arb.dm_write = 1'b0; arb.dm_addr = 32'h8; arb.dm_wdata = 32'h0; arb.dm_wstrb = 4'h0;
      cyc();
      n_checks++; if (arb.bus_valid !== 1'b1 || arb.bus_addr !== 32'h8) $display("FAIL first_grant: got valid %b addr %h required 1 00000008", arb.bus_valid, arb.bus_addr); else n_pass++;
      for (int i = 0; i < 20 && !got; i++) begin
         cyc();
         if (arb.dm_ack) got = 1'b1;
      end
      arb.dm_req = 1'b0;
      n_checks++; if (!got || arb.dm_rdata !== ref_rd(32'h8)) $display("FAIL first_read: got ack %b data %h required 1 %h", got, arb.dm_rdata, ref_rd(32'h8)); else n_pass++;
      cyc();
   endtask

   task automatic test_single_fetch();
      int cycles, n0, a0; logic [31:0] rd; bit got; txn_t t;
      slave_rand = 1'b0; slave_wait = 0;
      n0 = log_q.size(); a0 = if_ack_cnt;
      run_one(1'b1, 32'h100, 1'b0, 32'h0, 4'h0, cycles, rd, got);
      repeat (2) cyc();
      n_checks++; if (!got || cycles != 3) $display("FAIL fetch_latency: got ack %b after %0d cycles required 1 after 3", got, cycles); else n_pass++;
      n_checks++; if (rd !== 32'h00000013) $display("FAIL fetch_rdata: got %h required 00000013", rd); else n_pass++;
      n_checks++; if (if_ack_cnt - a0 != 1) $display("FAIL fetch_ack_pulse: got %0d ack cycles required 1", if_ack_cnt - a0); else n_pass++;
      t = (log_q.size() > n0) ? log_q[n0] : txn_t'('x);
      n_checks++; if (t !== txn_t'({1'b0, 32'h100, 32'h0, 4'h0})) $display("FAIL fetch_bus_txn: got %h required %h", t, txn_t'({1'b0, 32'h100, 32'h0, 4'h0})); else n_pass++;
   endtask

   task automatic test_collision();
      int dm_at = 0, if_at = 0, n0; logic [31:0] frd = 32'h0, exp_f;
      txn_t t0, t1;
      slave_rand = 1'b0; slave_wait = 0;
      n0 = log_q.size();
      exp_f = ref_rd(32'h104);
      ref_mem[32'h2000] = merge(ref_rd(32'h2000), 32'hDEADBEEF, 4'hF);
      arb.if_req = 1'b1; arb.if_addr = 32'h104;
      arb.dm_req = 1'b1; arb.dm_write = 1'b1; arb.dm_addr = 32'h2000; arb.dm_wdata = 32'hDEADBEEF; arb.dm_wstrb = 4'hF;
      for (int i = 1; i <= 40 && (arb.if_req || arb.dm_req); i++) begin
         cyc();
         if (arb.dm_ack) begin dm_at = i; arb.dm_req = 1'b0; end
         if (arb.if_ack) begin if_at = i; frd = arb.if_rdata; arb.if_req = 1'b0; end
      end
      idle_inputs();
      n_checks++; if (dm_at == 0 || if_at != dm_at + 3) $display("FAIL collision_order: got dm_ack at %0d if_ack at %0d required 3 and 6", dm_at, if_at); else n_pass++;
      n_checks++; if (frd !== exp_f) $display("FAIL collision_fetch_data: got %h required %h", frd, exp_f); else n_pass++;
      t0 = (log_q.size() > n0) ? log_q[n0] : txn_t'('x);
      t1 = (log_q.size() > n0 + 1) ? log_q[n0+1] : txn_t'('x);
      n_checks++; if (t0 !== txn_t'({1'b1, 32'h2000, 32'hDEADBEEF, 4'hF})) $display("FAIL collision_data_txn: got %h required %h", t0, txn_t'({1'b1, 32'h2000, 32'hDEADBEEF, 4'hF})); else n_pass++;
      n_checks++; if (t1 !== txn_t'({1'b0, 32'h104, 32'h0, 4'h0})) $display("FAIL collision_fetch_txn: got %h required %h", t1, txn_t'({1'b0, 32'h104, 32'h0, 4'h0})); else n_pass++;
   endtask

   task automatic test_wait_states();
      int cycles, n0, s0, a0; logic [31:0] rd, exp_r; bit got; txn_t t;
      slave_rand = 1'b0; slave_wait = 5;
      n0 = log_q.size(); s0 = stable_err; a0 = dm_ack_cnt;
      ref_mem[32'h40] = merge(ref_rd(32'h40), 32'h12345678, 4'h3);
      run_one(1'b0, 32'h40, 1'b1, 32'h12345678, 4'h3, cycles, rd, got);
      repeat (3) cyc();
      n_checks++; if (!got || cycles != 8) $display("FAIL wait_latency: got ack %b after %0d cycles required 1 after 8", got, cycles); else n_pass++;
      n_checks++; if (stable_err != s0) $display("FAIL wait_stable: got %0d unstable cycles required 0", stable_err - s0); else n_pass++;
      n_checks++; if (dm_ack_cnt - a0 != 1) $display("FAIL wait_ack_once: got %0d ack cycles required 1", dm_ack_cnt - a0); else n_pass++;
      t = (log_q.size() > n0) ? log_q[n0] : txn_t'('x);
      n_checks++; if (t !== txn_t'({1'b1, 32'h40, 32'h12345678, 4'h3})) $display("FAIL wait_txn: got %h required %h", t, txn_t'({1'b1, 32'h40, 32'h12345678, 4'h3})); else n_pass++;
      exp_r = ref_rd(32'h40);
      run_one(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, cycles, rd, got);
      cyc();
      n_checks++; if (!got || rd !== exp_r) $display("FAIL wait_strobe_readback: got ack %b data %h required 1 %h", got, rd, exp_r); else n_pass++;
   endtask

   task automatic test_flush();
      int n0, a0, cycles; bit seen = 1'b0, got; logic [31:0] rd, exp_r;
      slave_rand = 1'b0; slave_wait = 3;
      n0 = log_q.size(); a0 = if_ack_cnt;
      arb.if_req = 1'b1; arb.if_addr = 32'h200;
      for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = arb.bus_valid; end
      arb.pipe_flush = 1'b1; arb.if_req = 1'b0;
      cyc();
      arb.pipe_flush = 1'b0;
      for (int i = 0; i < 20 && log_q.size() == n0; i++) cyc();
      repeat (4) cyc();
      n_checks++; if (log_q.size() != n0 + 1 || log_q[log_q.size()-1].addr !== 32'h200) $display("FAIL flush_bus_completes: got %0d txns required 1 at 00000200", log_q.size() - n0); else n_pass++;
      n_checks++; if (if_ack_cnt != a0 || arb.bus_valid !== 1'b0) $display("FAIL flush_bus_no_ack: got %0d acks valid %b required 0 0", if_ack_cnt - a0, arb.bus_valid); else n_pass++;
      // flush landing in the ack cycle
      slave_wait = 0;
      arb.if_req = 1'b1; arb.if_addr = 32'h204;
      cyc();
      n_checks++; if (arb.bus_valid !== 1'b1) $display("FAIL flush_ack_grant: got valid %b required 1", arb.bus_valid); else n_pass++;
      cyc();
      arb.pipe_flush = 1'b1; arb.if_req = 1'b0;
      cyc();
      arb.pipe_flush = 1'b0;
      repeat (3) cyc();
      n_checks++; if (if_ack_cnt != a0) $display("FAIL flush_ack_no_ack: got %0d acks required 0", if_ack_cnt - a0); else n_pass++;
      // flush never affects data
      arb.pipe_flush = 1'b1;
      exp_r = ref_rd(32'h300);
      run_one(1'b0, 32'h300, 1'b0, 32'h0, 4'h0, cycles, rd, got);
      arb.pipe_flush = 1'b0;
      n_checks++; if (!got || cycles != 3 || rd !== exp_r) $display("FAIL flush_data_unaffected: got ack %b cycles %0d data %h required 1 3 %h", got, cycles, rd, exp_r); else n_pass++;
      exp_r = ref_rd(32'h104);
      run_one(1'b1, 32'h104, 1'b0, 32'h0, 4'h0, cycles, rd, got);
      cyc();
      n_checks++; if (!got || rd !== exp_r) $display("FAIL flush_next_fetch: got ack %b data %h required 1 %h", got, rd, exp_r); else n_pass++;
   endtask

   task automatic test_random();
      slave_rand = 1'b1;
      for (int it = 0; it < 40; it++) begin
         int kind, n0; logic [31:0] fa, da, dw; logic [3:0] ds; bit dwr, want_f, want_d, fetch_first;
         bit ord[$]; txn_t exp_t[$]; logic [31:0] exp_d[$]; bit exp_c[$]; bit got_f[$]; logic [31:0] got_d[$];
         kind = int'($urandom_range(0, 2));
         fa = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         da = 32'h1000 + 32'(4 * $urandom_range(0, 7));
         dwr = 1'($urandom_range(0, 1)); dw = $urandom; ds = 4'($urandom_range(1, 15));
         want_f = (kind != 1); want_d = (kind != 0);
         fetch_first = want_f && (!want_d || (GUARD && model_starve == LIMIT));
         if (want_f && want_d) begin ord.push_back(fetch_first); ord.push_back(!fetch_first); end
         else ord.push_back(want_f);
         foreach (ord[j]) begin
            if (ord[j]) begin
               exp_t.push_back(txn_t'({1'b0, fa, 32'h0, 4'h0})); exp_d.push_back(ref_rd(fa)); exp_c.push_back(1'b1);
               model_starve = 0;
            end else begin
               exp_t.push_back(txn_t'({dwr, da, dw, ds})); exp_d.push_back(ref_rd(da)); exp_c.push_back(!dwr);
               if (dwr) ref_mem[da] = merge(ref_rd(da), dw, ds);
               if (want_f && j == 0) model_starve++;
            end
         end
         n0 = log_q.size();
         arb.pipe_flush = want_f ? 1'b0 : 1'($urandom_range(0, 1));
         if (want_f) begin arb.if_req = 1'b1; arb.if_addr = fa; end
         if (want_d) begin arb.dm_req = 1'b1; arb.dm_write = dwr; arb.dm_addr = da; arb.dm_wdata = dw; arb.dm_wstrb = ds; end
         for (int c = 0; c < 100 && (arb.if_req || arb.dm_req); c++) begin
            cyc();
            if (arb.if_ack) begin got_f.push_back(1'b1); got_d.push_back(arb.if_rdata); arb.if_req = 1'b0; end
            if (arb.dm_ack) begin got_f.push_back(1'b0); got_d.push_back(arb.dm_rdata); arb.dm_req = 1'b0; end
         end
         idle_inputs();
         n_checks++; if (got_f.size() != ord.size()) $display("FAIL rand_ack_count it%0d: got %0d acks required %0d", it, got_f.size(), ord.size()); else n_pass++;
         for (int j = 0; j < ord.size() && j < got_f.size(); j++) begin
            n_checks++; if (got_f[j] !== ord[j]) $display("FAIL rand_order it%0d.%0d: got fetch=%b required fetch=%b", it, j, got_f[j], ord[j]); else n_pass++;
            if (exp_c[j]) begin
               n_checks++; if (got_d[j] !== exp_d[j]) $display("FAIL rand_rdata it%0d.%0d: got %h required %h", it, j, got_d[j], exp_d[j]); else n_pass++;
            end
         end
         n_checks++; if (log_q.size() - n0 != exp_t.size()) $display("FAIL rand_txn_count it%0d: got %0d required %0d", it, log_q.size() - n0, exp_t.size()); else n_pass++;
         for (int j = 0; j < exp_t.size() && n0 + j < log_q.size(); j++) begin
            n_checks++; if (log_q[n0+j] !== exp_t[j]) $display("FAIL rand_txn it%0d.%0d: got %h required %h", it, j, log_q[n0+j], exp_t[j]); else n_pass++;
         end
         repeat ($urandom_range(0, 2)) cyc();
      end
      slave_rand = 1'b0;
   endtask

   task automatic test_guard();
      int d = 0, d_at = -1, expd;
      apply_reset();
      model_starve = 0;
      slave_wait = 0;
      arb.dm_req = 1'b1; arb.dm_write = 1'b0; arb.dm_addr = 32'h10; arb.dm_wdata = 32'h0; arb.dm_wstrb = 4'h0;
      arb.if_req = 1'b1; arb.if_addr = 32'h104;
      for (int i = 0; i < 200 && d_at < 0; i++) begin
         cyc();
         if (arb.dm_ack) d++;
         if (arb.if_ack) d_at = d;
         if (!GUARD && d == 8) arb.dm_req = 1'b0;
      end
      idle_inputs();
      repeat (4) cyc();
      expd = GUARD ? int'(LIMIT) : 8;
      n_checks++; if (d_at != expd) $display("FAIL guard_data_grants_before_fetch: got %0d required %0d", d_at, expd); else n_pass++;
   endtask

   task automatic test_reset_mid_bus();
      int a_if, a_dm; bit seen = 1'b0;
      slave_wait = 10;
      arb.if_req = 1'b1; arb.if_addr = 32'h104;
      for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = arb.bus_valid; end
      cyc();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (!seen || arb.bus_valid !== 1'b0 || arb.bus_addr !== 32'h0) $display("FAIL reset_async_drop: got seen %b valid %b addr %h required 1 0 0", seen, arb.bus_valid, arb.bus_addr); else n_pass++;
      idle_inputs();
      cyc();
      rst_n = 1'b1;
      a_if = if_ack_cnt; a_dm = dm_ack_cnt;
      repeat (15) cyc();
      n_checks++; if (if_ack_cnt != a_if || dm_ack_cnt != a_dm || arb.bus_valid !== 1'b0) $display("FAIL reset_no_ack_after: got %0d/%0d acks valid %b required 0/0 0", if_ack_cnt - a_if, dm_ack_cnt - a_dm, arb.bus_valid); else n_pass++;
      slave_wait = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      mem[32'h100]     = 32'h00000013;
      ref_mem[32'h100] = 32'h00000013;
      test_reset();
      test_single_fetch();
      test_collision();
      test_wait_states();
      test_flush();
      test_random();
      test_guard();
      test_reset_mid_bus();
      n_checks++; if (both_cnt != 0) $display("FAIL acks_exclusive: got %0d cycles with both acks required 0", both_cnt); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
